// File: rtl/cu_sequencer_if.sv
// Instruction-fetch, issue and status bundle between cu_sequencer and its surroundings.
// master: the sequencer side. slave: the memory / execution-unit / controller side.
interface cu_sequencer_if #(
  parameter int unsigned ADDR_W = 4
);
  logic              start;
  logic              instr_rd_en;
  logic [ADDR_W-1:0] instr_addr;
  logic [15:0]       instr_data;
  logic [3:0]        opcode;
  logic [2:0]        dest_reg;
  logic [2:0]        opAAdr;
  logic [2:0]        opBAder;
  logic [3:0]        storeDataAdr;
  logic [3:0]        loadDataAdr;
  logic              busy;
  logic              done;
  logic [15:0]       retired_cnt;

  modport master (
    input  start, instr_data,
    output instr_rd_en, instr_addr, opcode, dest_reg, opAAdr, opBAder,
           storeDataAdr, loadDataAdr, busy, done, retired_cnt
  );

  modport slave (
    output start, instr_data,
    input  instr_rd_en, instr_addr, opcode, dest_reg, opAAdr, opBAder,
           storeDataAdr, loadDataAdr, busy, done, retired_cnt
  );
endinterface

// File: rtl/cu_sequencer.sv
// Control-unit sequencer: fetch/decode/exec/wb over a fixed-length program from address 0.
// Optional macro CU_RETIRE_CNT_EN enables the saturating retired-instruction counter.
module cu_sequencer #(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned PROG_LEN = 16
) (
  input logic             clk,
  input logic             reset,
  cu_sequencer_if.master  bus
);

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_LEN - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              instr_rd_en;
  logic [3:0]        opcode;
  logic [2:0]        dest_reg;
  logic [2:0]        op_a_adr;
  logic [2:0]        op_b_adr;
  logic [3:0]        store_adr;
  logic [3:0]        load_adr;
  logic              busy;
  logic              done;

  logic [3:0] dec_opcode_c;
  logic [2:0] dec_dest_c;
  logic [2:0] dec_op_a_c;
  logic [2:0] dec_op_b_c;
  logic [3:0] dec_store_c;
  logic [3:0] dec_load_c;

  // Field extraction; anything a format does not use stays 0.
  always_comb begin
    dec_opcode_c = bus.instr_data[15:12];
    dec_dest_c   = 3'd0;
    dec_op_a_c   = 3'd0;
    dec_op_b_c   = 3'd0;
    dec_store_c  = 4'd0;
    dec_load_c   = 4'd0;
    case (bus.instr_data[15:12])
      4'b1110: begin
        dec_dest_c = bus.instr_data[11:9];
        dec_load_c = bus.instr_data[3:0];
      end
      4'b1111: begin
        dec_store_c = bus.instr_data[11:8];
        dec_op_a_c  = bus.instr_data[7:5];
      end
      default: begin
        dec_dest_c = bus.instr_data[11:9];
        dec_op_a_c = bus.instr_data[8:6];
        dec_op_b_c = bus.instr_data[5:3];
      end
    endcase
  end

  // Sequencer FSM; every output is updated alongside the state it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= '0;
      instr_rd_en <= 1'b0;
      opcode      <= 4'd0;
      dest_reg    <= 3'd0;
      op_a_adr    <= 3'd0;
      op_b_adr    <= 3'd0;
      store_adr   <= 4'd0;
      load_adr    <= 4'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            pc          <= '0;
            instr_rd_en <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b0;
            state       <= FETCH;
          end
        end
        FETCH: begin
          instr_rd_en <= 1'b0;
          state       <= DECODE;
        end
        DECODE: begin
          opcode    <= dec_opcode_c;
          dest_reg  <= dec_dest_c;
          op_a_adr  <= dec_op_a_c;
          op_b_adr  <= dec_op_b_c;
          store_adr <= dec_store_c;
          load_adr  <= dec_load_c;
          state     <= EXEC;
        end
        EXEC: begin
          state <= WB;
        end
        WB: begin
          if (pc == LAST_PC) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            pc          <= pc + ADDR_W'(1);
            instr_rd_en <= 1'b1;
            state       <= FETCH;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef CU_RETIRE_CNT_EN
  logic [15:0] retired_cnt;

  // Counts WB exits across runs; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_cnt <= 16'd0;
    end else if (state == WB && retired_cnt != 16'hFFFF) begin
      retired_cnt <= retired_cnt + 16'd1;
    end
  end

  assign bus.retired_cnt = retired_cnt;
`else
  assign bus.retired_cnt = 16'd0;
`endif

  assign bus.instr_rd_en  = instr_rd_en;
  assign bus.instr_addr   = pc;
  assign bus.opcode       = opcode;
  assign bus.dest_reg     = dest_reg;
  assign bus.opAAdr       = op_a_adr;
  assign bus.opBAder      = op_b_adr;
  assign bus.storeDataAdr = store_adr;
  assign bus.loadDataAdr  = load_adr;
  assign bus.busy         = busy;
  assign bus.done         = done;

endmodule

// File: tb/tb_cu_sequencer.sv
// Directed bench for cu_sequencer: decode formats, full runs, ignored start, mid-run reset.
module tb_cu_sequencer;

  logic clk = 1'b0;
  logic reset;

  cu_sequencer_if #(.ADDR_W(4)) bus ();

  cu_sequencer #(.ADDR_W(4), .PROG_LEN(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [16];

  // Synchronous instruction memory: data one cycle after the read strobe.
  always @(posedge clk) begin
    if (bus.instr_rd_en) bus.instr_data <= mem[bus.instr_addr];
  end

  int checks = 0;
  int errors = 0;

`ifdef CU_RETIRE_CNT_EN
  localparam int unsigned CNT_MUL = 1;
`else
  localparam int unsigned CNT_MUL = 0;
`endif

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_fields(input string tag, input int op, input int d, input int a,
                              input int b, input int s, input int l);
    check({tag, " opcode"},       32'(bus.opcode),       32'(op));
    check({tag, " dest_reg"},     32'(bus.dest_reg),     32'(d));
    check({tag, " opAAdr"},       32'(bus.opAAdr),       32'(a));
    check({tag, " opBAder"},      32'(bus.opBAder),      32'(b));
    check({tag, " storeDataAdr"}, 32'(bus.storeDataAdr), 32'(s));
    check({tag, " loadDataAdr"},  32'(bus.loadDataAdr),  32'(l));
  endtask

  // Walks one full program from the first FETCH to DONE (64 cycles).
  task automatic run_program(input int run);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("r%0d fetch addr %0d", run, i), 32'(bus.instr_addr), 32'(i));
      check($sformatf("r%0d fetch rd_en %0d", run, i), 32'(bus.instr_rd_en), 32'd1);
      check($sformatf("r%0d fetch busy %0d", run, i), 32'(bus.busy), 32'd1);
      tick(1);
      check($sformatf("r%0d decode rd_en %0d", run, i), 32'(bus.instr_rd_en), 32'd0);
      tick(1);
      if (i == 0 && run == 0) check_fields("r0 alu exec", 1, 5, 2, 3, 0, 0);
      if (i == 0 && run == 1) check_fields("r1 load exec", 14, 3, 0, 0, 0, 7);
      if (i == 1)             check_fields($sformatf("r%0d store exec", run), 15, 0, 5, 0, 9, 0);
      if (i == 2) bus.start = 1'b1;
      tick(1);
      bus.start = 1'b0;
      if (i == 1) check($sformatf("r%0d wb hold storeDataAdr", run), 32'(bus.storeDataAdr), 32'd9);
      check($sformatf("r%0d wb busy %0d", run, i), 32'(bus.busy), 32'd1);
      check($sformatf("r%0d wb done %0d", run, i), 32'(bus.done), 32'd0);
      tick(1);
    end
    check($sformatf("r%0d done", run), 32'(bus.done), 32'd1);
    check($sformatf("r%0d busy after", run), 32'(bus.busy), 32'd0);
    check($sformatf("r%0d retired_cnt", run), 32'(bus.retired_cnt), 32'(16 * (run + 1) * CNT_MUL));
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'h3B5F;
    mem[0] = 16'h1A98;
    mem[1] = 16'hF9A0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.instr_data = 16'h0000;
    tick(2);
    reset = 1'b0;
    tick(1);

    check("reset busy",        32'(bus.busy),        32'd0);
    check("reset done",        32'(bus.done),        32'd0);
    check("reset rd_en",       32'(bus.instr_rd_en), 32'd0);
    check("reset addr",        32'(bus.instr_addr),  32'd0);
    check("reset retired_cnt", 32'(bus.retired_cnt), 32'd0);
    check_fields("reset", 0, 0, 0, 0, 0, 0);

    // Run 0: ALU at address 0, store at address 1, ignored start in EXEC of instr 2.
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    run_program(0);
    tick(2);
    check("done held", 32'(bus.done), 32'd1);
    check("done fields held", 32'(bus.opcode), 32'h3);

    // Run 1: restart from DONE with a load at address 0.
    mem[0] = 16'hE607;
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    check("restart done low", 32'(bus.done), 32'd0);
    run_program(1);

    // Run 2: reset during DECODE of instruction 5.
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    tick(20);
    check("r2 fetch addr 5", 32'(bus.instr_addr), 32'd5);
    check("r2 pre-reset opcode", 32'(bus.opcode), 32'h3);
    tick(1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("abort busy",        32'(bus.busy),        32'd0);
    check("abort done",        32'(bus.done),        32'd0);
    check("abort rd_en",       32'(bus.instr_rd_en), 32'd0);
    check("abort addr",        32'(bus.instr_addr),  32'd0);
    check("abort retired_cnt", 32'(bus.retired_cnt), 32'd0);
    check_fields("abort", 0, 0, 0, 0, 0, 0);
    tick(1);
    check("idle stays idle", 32'(bus.busy), 32'd0);

    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    check("refetch addr",  32'(bus.instr_addr),  32'd0);
    check("refetch rd_en", 32'(bus.instr_rd_en), 32'd1);
    check("refetch busy",  32'(bus.busy),        32'd1);
    tick(2);
    check_fields("refetch exec", 14, 3, 0, 0, 0, 7);

    // Reset and start together: reset wins.
    reset = 1'b1;
    bus.start = 1'b1;
    tick(1);
    reset = 1'b0;
    bus.start = 1'b0;
    check("reset+start busy",  32'(bus.busy),        32'd0);
    check("reset+start rd_en", 32'(bus.instr_rd_en), 32'd0);
    tick(1);
    check("reset+start idle", 32'(bus.busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cu_sequencer.md
# cu_sequencer

Control-unit sequencer that drives the execution unit: it fetches 16-bit instructions from a synchronous instruction memory, decodes them into opcode, destination, operand-address and data-memory-address fields, and holds each issue for the execution unit's registered execute and write-back cycles. It sits between the instruction memory and the execution unit. It runs a fixed-length program from address 0 on each `start` and reports `busy` and `done`.

## Interface
- `ADDR_W`, 4, instruction address width
- `PROG_LEN`, 16, number of instructions per run (1..2^ADDR_W)

- `clk`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-high; one clock, `clk`
- `start`  in  1  begin a run; sampled only in IDLE or DONE
- `instr_rd_en`  out  1  instruction memory read strobe
- `instr_addr`  out  ADDR_W  instruction memory address (= pc)
- `instr_data`  in  16  instruction word, valid one cycle after `instr_rd_en`
- `opcode`  out  4  opcode to execution unit
- `dest_reg`  out  3  destination register
- `opAAdr`  out  3  operand A register address
- `opBAder`  out  3  operand B register address
- `storeDataAdr`  out  4  data-memory store address
- `loadDataAdr`  out  4  data-memory load address
- `busy`  out  1  run in progress
- `done`  out  1  run complete, held until next `start` or `reset`
- `retired_cnt`  out  16  retired-instruction count (see Configuration)

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WB, DONE.
- IDLE: `start`=1 -> pc=0, FETCH.
- FETCH: `instr_rd_en`=1, `instr_addr`=pc -> DECODE.
- DECODE: capture `instr_data`, register the decoded fields onto the outputs at the end of the cycle -> EXEC.
- EXEC: fields stable. The execution unit samples them on the closing edge -> WB.
- WB: fields stay stable for register/data-memory write-back. On exit: if pc==PROG_LEN-1 -> DONE, else pc+1 -> FETCH.
- DONE: `done`=1. `start`=1 -> pc=0, `done`=0, FETCH.
- Decode fields, opcode = instr[15:12]:
  - ALU (0000–1101): dest_reg=[11:9], opAAdr=[8:6], opBAder=[5:3]
  - load (1110): dest_reg=[11:9], loadDataAdr=[3:0]
  - store (1111): storeDataAdr=[11:8], opAAdr=[7:5]
  - any field not used by the format is driven 0. Bits not named are ignored.
- Issue fields hold their last decoded value in IDLE, DONE and FETCH. They change only at the end of DECODE.
- `start` in FETCH/DECODE/EXEC/WB is ignored.
- pc is ADDR_W bits wide. It never wraps within a run, because the run terminates at PROG_LEN-1.

## Timing
- Fixed 4 cycles per instruction (FETCH, DECODE, EXEC, WB). A run takes 4·PROG_LEN cycles from the first FETCH to DONE.
- `busy`=1 exactly in FETCH, DECODE, EXEC and WB.
- `done` rises on the cycle after the last WB.
- Reset values: state=IDLE, pc=0, `instr_rd_en`=0, `instr_addr`=0, all issue fields 0, `busy`=0, `done`=0, `retired_cnt`=0.
- A reset asserted mid-run aborts on the next edge to the reset values. The instruction in flight is not retired.
- `start` and `reset` asserted together: reset wins.

## Configuration
- `CU_RETIRE_CNT_EN` defined:
  - `retired_cnt` increments by 1 on every WB exit and saturates at 16'hFFFF.
  - It clears only on `reset`, and is not cleared by `start`.
- `CU_RETIRE_CNT_EN` undefined: `retired_cnt` is tied to 0 and no counter is synthesized.

## Test plan
- Reset, then `start` with memory[0]=16'h1A98 (ALU 0001, dest 5, A 2, B 3): at EXEC, `opcode`=1, `dest_reg`=5, `opAAdr`=2, `opBAder`=3, `storeDataAdr`=0, `loadDataAdr`=0.
- Load 16'hE607 at addr 0: in EXEC, `opcode`=14, `dest_reg`=3, `loadDataAdr`=7, `opAAdr`=0, `opBAder`=0. Store 16'hF9A0 at addr 1: in EXEC, `storeDataAdr`=9, `opAAdr`=5, `dest_reg`=0.
- PROG_LEN=16 full run: `instr_addr` steps 0..15, `done` rises 64 cycles after the first FETCH, `busy` falls the same cycle. With `CU_RETIRE_CNT_EN`, `retired_cnt`=16.
- Pulse `start` during EXEC of instruction 2: no effect, and the sequence continues to `done`.
- Assert `reset` in DECODE of instruction 5: next cycle state IDLE, pc 0, all outputs 0. A second `start` refetches from address 0.
- From DONE, pulse `start`: `done` falls, FETCH at addr 0. With the macro, `retired_cnt` continues from 16 to 32 after the second run.
